// File: rtl/reservation_station_pkg.sv
// Shared types for the ALU reservation station: opcodes, ROB tag width,
// entry layout and the CDB snoop helper.
package reservation_station_pkg;

   localparam int ROB_W       = 6;
   localparam int RS_SIZE_DEF = 16;

   localparam logic [5:0] OP_ADD  = 6'd1;
   localparam logic [5:0] OP_SUB  = 6'd2;
   localparam logic [5:0] OP_AND  = 6'd3;
   localparam logic [5:0] OP_OR   = 6'd4;
   localparam logic [5:0] OP_XOR  = 6'd5;
   localparam logic [5:0] OP_SLL  = 6'd6;
   localparam logic [5:0] OP_SRL  = 6'd7;
   localparam logic [5:0] OP_SRA  = 6'd8;
   localparam logic [5:0] OP_SLT  = 6'd9;
   localparam logic [5:0] OP_SLTU = 6'd10;
   localparam logic [5:0] OP_ADDI = 6'd11;
   localparam logic [5:0] OP_LUI  = 6'd12;

   typedef logic [ROB_W-1:0] rob_idx_t;

   typedef struct packed {
      logic        has_dep;
      rob_idx_t    dep;
      logic [31:0] val;
   } opnd_t;

   typedef struct packed {
      logic [5:0]  opcode;
      opnd_t       op1;
      opnd_t       op2;
      logic [31:0] imm;
      logic [31:0] pc;
      rob_idx_t    rob_index;
   } rs_entry_t;

   typedef struct packed {
      logic [5:0]  opcode;
      logic [31:0] val1;
      logic [31:0] val2;
      logic [31:0] imm;
      logic [31:0] pc;
      rob_idx_t    rob_index;
   } alu_out_t;

   typedef struct packed {
      logic        valid;
      rob_idx_t    index;
      logic [31:0] value;
   } cdb_t;

   // ALU bus wins when both buses carry the awaited tag.
   function automatic opnd_t wake(opnd_t o, cdb_t a, cdb_t l);
      opnd_t r;
      r = o;
      if (o.has_dep) begin
         if (a.valid && a.index == o.dep) begin
            r.has_dep = 1'b0;
            r.val     = a.value;
         end else if (l.valid && l.index == o.dep) begin
            r.has_dep = 1'b0;
            r.val     = l.value;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Issue, CDB snoop and ALU dispatch signals of the reservation station.
interface reservation_station_if;
   import reservation_station_pkg::*;

   logic        rs_valid;
   logic [5:0]  rs_opcode;
   logic [31:0] rs_val1;
   rob_idx_t    rs_dep1;
   logic        rs_has_dep1;
   logic [31:0] rs_val2;
   rob_idx_t    rs_dep2;
   logic        rs_has_dep2;
   rob_idx_t    rs_rob_index;
   logic [31:0] rs_imm;
   logic [31:0] rs_pc;
   logic        rs_full;

   logic        alu_cdb_valid;
   rob_idx_t    alu_cdb_index;
   logic [31:0] alu_cdb_value;
   logic        lsb_cdb_valid;
   rob_idx_t    lsb_cdb_index;
   logic [31:0] lsb_cdb_value;

   logic        alu_valid;
   logic [5:0]  alu_opcode;
   logic [31:0] alu_val1;
   logic [31:0] alu_val2;
   logic [31:0] alu_imm;
   logic [31:0] alu_pc;
   rob_idx_t    alu_rob_index;

   modport master (
      output rs_valid, rs_opcode, rs_val1, rs_dep1, rs_has_dep1,
             rs_val2, rs_dep2, rs_has_dep2, rs_rob_index, rs_imm, rs_pc,
             alu_cdb_valid, alu_cdb_index, alu_cdb_value,
             lsb_cdb_valid, lsb_cdb_index, lsb_cdb_value,
      input  rs_full, alu_valid, alu_opcode, alu_val1, alu_val2,
             alu_imm, alu_pc, alu_rob_index
   );

   modport slave (
      input  rs_valid, rs_opcode, rs_val1, rs_dep1, rs_has_dep1,
             rs_val2, rs_dep2, rs_has_dep2, rs_rob_index, rs_imm, rs_pc,
             alu_cdb_valid, alu_cdb_index, alu_cdb_value,
             lsb_cdb_valid, lsb_cdb_index, lsb_cdb_value,
      output rs_full, alu_valid, alu_opcode, alu_val1, alu_val2,
             alu_imm, alu_pc, alu_rob_index
   );

endinterface

// File: rtl/reservation_station_select_lowest.sv
// Fixed-priority encoder: index of the lowest set request bit.
module reservation_station_select_lowest #(
   parameter int N = 16,
   localparam int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   output logic [W-1:0] idx,
   output logic         found
);

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: free-slot array that snoops both CDBs and
// dispatches the lowest-index ready entry each cycle.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int RS_SIZE = RS_SIZE_DEF
) (
   input logic                  clk,
   input logic                  rst,
   input logic                  rdy,
   input logic                  flush,
   reservation_station_if.slave io
);

   localparam int IW = $clog2(RS_SIZE);
   localparam int CW = IW + 1;

   logic [RS_SIZE-1:0] busy, busy_n, ready;
   rs_entry_t          ent   [RS_SIZE];
   rs_entry_t          ent_n [RS_SIZE];
   logic [IW-1:0]      free_idx, pick_idx;
   logic               free_found, pick_found;
   logic [CW-1:0]      free_cnt;
   alu_out_t           alu_q, alu_n;
   logic               alu_valid_q, alu_valid_n;
   cdb_t               acdb, lcdb;
   opnd_t              in1, in2;
   rs_entry_t          in_ent;

   assign acdb = '{valid: io.alu_cdb_valid, index: io.alu_cdb_index,
                   value: io.alu_cdb_value};
   assign lcdb = '{valid: io.lsb_cdb_valid, index: io.lsb_cdb_index,
                   value: io.lsb_cdb_value};

   always_comb begin
      ready    = '0;
      free_cnt = '0;
      for (int i = 0; i < RS_SIZE; i++) begin
         ready[i] = busy[i] & ~ent[i].op1.has_dep & ~ent[i].op2.has_dep;
         if (!busy[i]) free_cnt = free_cnt + CW'(1);
      end
   end

   // One slot of headroom covers the issue already in flight upstream.
   assign io.rs_full = free_cnt <= CW'(1);

   reservation_station_select_lowest #(.N(RS_SIZE)) u_free (
      .req   (~busy),
      .idx   (free_idx),
      .found (free_found)
   );

   reservation_station_select_lowest #(.N(RS_SIZE)) u_pick (
      .req   (ready),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_comb begin
      in1 = '{has_dep: io.rs_has_dep1, dep: io.rs_dep1, val: io.rs_val1};
      in2 = '{has_dep: io.rs_has_dep2, dep: io.rs_dep2, val: io.rs_val2};
      in_ent.opcode    = io.rs_opcode;
      in_ent.op1       = wake(in1, acdb, lcdb);
      in_ent.op2       = wake(in2, acdb, lcdb);
      in_ent.imm       = io.rs_imm;
      in_ent.pc        = io.rs_pc;
      in_ent.rob_index = io.rs_rob_index;
   end

   always_comb begin
      busy_n      = busy;
      ent_n       = ent;
      alu_n       = alu_q;
      alu_valid_n = 1'b0;
      if (flush) begin
         busy_n = '0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy[i]) begin
               ent_n[i].op1 = wake(ent[i].op1, acdb, lcdb);
               ent_n[i].op2 = wake(ent[i].op2, acdb, lcdb);
            end
         end
         if (pick_found) begin
            alu_valid_n     = 1'b1;
            alu_n.opcode    = ent[pick_idx].opcode;
            alu_n.val1      = ent[pick_idx].op1.val;
            alu_n.val2      = ent[pick_idx].op2.val;
            alu_n.imm       = ent[pick_idx].imm;
            alu_n.pc        = ent[pick_idx].pc;
            alu_n.rob_index = ent[pick_idx].rob_index;
            busy_n[pick_idx] = 1'b0;
         end
         // Free slot comes from the pre-dispatch busy vector.
         if (io.rs_valid && free_found) begin
            ent_n[free_idx]  = in_ent;
            busy_n[free_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= '0;
         alu_valid_q <= 1'b0;
         alu_q       <= '0;
      end else if (rdy) begin
         busy        <= busy_n;
         alu_valid_q <= alu_valid_n;
         alu_q       <= alu_n;
      end
   end

   always_ff @(posedge clk) begin
      if (rdy) ent <= ent_n;
   end

   assign io.alu_valid     = alu_valid_q;
   assign io.alu_opcode    = alu_q.opcode;
   assign io.alu_val1      = alu_q.val1;
   assign io.alu_val2      = alu_q.val2;
   assign io.alu_imm       = alu_q.imm;
   assign io.alu_pc        = alu_q.pc;
   assign io.alu_rob_index = alu_q.rob_index;

   issue_needs_slot: assert property (
      @(posedge clk) disable iff (rst)
      (rdy && !flush && io.rs_valid) |-> free_found
   );

endmodule

// File: tb/tb_reservation_station.sv
// Directed self-checking bench for reservation_station.
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic clk = 1'b0;
   logic rst, rdy, flush;
   int   checks = 0;
   int   fails  = 0;

   reservation_station_if bus ();

   reservation_station dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .flush (flush),
      .io    (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic issue(logic [5:0] op, logic [31:0] v1, logic h1,
                        logic [5:0] d1, logic [31:0] v2, logic h2,
                        logic [5:0] d2, logic [5:0] rob, logic [31:0] imm);
      bus.rs_valid     = 1'b1;
      bus.rs_opcode    = op;
      bus.rs_val1      = v1;
      bus.rs_has_dep1  = h1;
      bus.rs_dep1      = d1;
      bus.rs_val2      = v2;
      bus.rs_has_dep2  = h2;
      bus.rs_dep2      = d2;
      bus.rs_rob_index = rob;
      bus.rs_imm       = imm;
      bus.rs_pc        = 32'h1000 + 32'(rob) * 4;
      step();
      bus.rs_valid     = 1'b0;
   endtask

   task automatic bcast_alu(logic [5:0] idx, logic [31:0] v);
      bus.alu_cdb_valid = 1'b1;
      bus.alu_cdb_index = idx;
      bus.alu_cdb_value = v;
      step();
      bus.alu_cdb_valid = 1'b0;
   endtask

   task automatic bcast_lsb(logic [5:0] idx, logic [31:0] v);
      bus.lsb_cdb_valid = 1'b1;
      bus.lsb_cdb_index = idx;
      bus.lsb_cdb_value = v;
      step();
      bus.lsb_cdb_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      rdy = 1'b1;
      flush = 1'b0;
      bus.rs_valid = 1'b0;
      bus.rs_opcode = '0;
      bus.rs_val1 = '0;
      bus.rs_dep1 = '0;
      bus.rs_has_dep1 = 1'b0;
      bus.rs_val2 = '0;
      bus.rs_dep2 = '0;
      bus.rs_has_dep2 = 1'b0;
      bus.rs_rob_index = '0;
      bus.rs_imm = '0;
      bus.rs_pc = '0;
      bus.alu_cdb_valid = 1'b0;
      bus.alu_cdb_index = '0;
      bus.alu_cdb_value = '0;
      bus.lsb_cdb_valid = 1'b0;
      bus.lsb_cdb_index = '0;
      bus.lsb_cdb_value = '0;

      // reset then idle
      step();
      step();
      chk("rst_valid", 32'(bus.alu_valid), 0);
      chk("rst_full", 32'(bus.rs_full), 0);
      chk("rst_val1", bus.alu_val1, 0);
      chk("rst_rob", 32'(bus.alu_rob_index), 0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle_valid", 32'(bus.alu_valid), 0);
         chk("idle_full", 32'(bus.rs_full), 0);
      end

      // ready issue: dispatch on the second edge
      issue(OP_ADDI, 5, 0, 0, 0, 0, 0, 3, 7);
      chk("addi_early", 32'(bus.alu_valid), 0);
      step();
      chk("addi_valid", 32'(bus.alu_valid), 1);
      chk("addi_val1", bus.alu_val1, 5);
      chk("addi_imm", bus.alu_imm, 7);
      chk("addi_rob", 32'(bus.alu_rob_index), 3);
      chk("addi_op", 32'(bus.alu_opcode), 32'(OP_ADDI));
      chk("addi_pc", bus.alu_pc, 32'h100C);
      step();
      chk("addi_once", 32'(bus.alu_valid), 0);
      chk("addi_hold", bus.alu_val1, 5);

      // wakeup from ALU bus
      issue(OP_ADD, 0, 1, 4, 2, 0, 0, 5, 0);
      step();
      chk("wk_alu_wait", 32'(bus.alu_valid), 0);
      bcast_alu(4, 32'h10);
      chk("wk_alu_t", 32'(bus.alu_valid), 0);
      step();
      chk("wk_alu_valid", 32'(bus.alu_valid), 1);
      chk("wk_alu_val1", bus.alu_val1, 32'h10);
      chk("wk_alu_val2", bus.alu_val2, 2);
      chk("wk_alu_rob", 32'(bus.alu_rob_index), 5);

      // wakeup from load bus
      issue(OP_ADD, 0, 1, 4, 3, 0, 0, 6, 0);
      step();
      bcast_lsb(4, 32'h20);
      chk("wk_lsb_t", 32'(bus.alu_valid), 0);
      step();
      chk("wk_lsb_valid", 32'(bus.alu_valid), 1);
      chk("wk_lsb_val1", bus.alu_val1, 32'h20);
      chk("wk_lsb_rob", 32'(bus.alu_rob_index), 6);

      // tag 0 on both buses: ALU value wins
      issue(OP_SUB, 9, 0, 0, 0, 1, 0, 7, 0);
      bus.alu_cdb_index = 0;
      bus.alu_cdb_value = 32'h111;
      bus.lsb_cdb_index = 0;
      bus.lsb_cdb_value = 32'h222;
      bus.alu_cdb_valid = 1'b1;
      bus.lsb_cdb_valid = 1'b1;
      step();
      bus.alu_cdb_valid = 1'b0;
      bus.lsb_cdb_valid = 1'b0;
      chk("prio_t", 32'(bus.alu_valid), 0);
      step();
      chk("prio_valid", 32'(bus.alu_valid), 1);
      chk("prio_val2", bus.alu_val2, 32'h111);
      chk("prio_val1", bus.alu_val1, 9);
      chk("prio_rob", 32'(bus.alu_rob_index), 7);

      // same-cycle forward at issue
      bus.lsb_cdb_valid = 1'b1;
      bus.lsb_cdb_index = 9;
      bus.lsb_cdb_value = 32'hABCD;
      issue(OP_XOR, 1, 0, 0, 32'hDEAD, 1, 9, 8, 0);
      bus.lsb_cdb_valid = 1'b0;
      chk("fwd_early", 32'(bus.alu_valid), 0);
      step();
      chk("fwd_valid", 32'(bus.alu_valid), 1);
      chk("fwd_val2", bus.alu_val2, 32'hABCD);
      chk("fwd_rob", 32'(bus.alu_rob_index), 8);

      // fill 15 entries waiting on tag 1
      for (int i = 0; i < 15; i++) begin
         issue(OP_ADD, 0, 1, 1, 32'(i), 0, 0, 6'(16 + i), 0);
         if (i == 13) chk("fill_14_full", 32'(bus.rs_full), 0);
      end
      chk("fill_15_full", 32'(bus.rs_full), 1);
      chk("fill_no_disp", 32'(bus.alu_valid), 0);
      bcast_alu(1, 32'h77);
      chk("fill_wake_full", 32'(bus.rs_full), 1);
      chk("fill_wake_valid", 32'(bus.alu_valid), 0);
      for (int i = 0; i < 15; i++) begin
         step();
         chk("drain_valid", 32'(bus.alu_valid), 1);
         chk("drain_rob", 32'(bus.alu_rob_index), 32'(16 + i));
         chk("drain_val2", bus.alu_val2, 32'(i));
         if (i == 0) begin
            chk("drain_full", 32'(bus.rs_full), 0);
            chk("drain_val1", bus.alu_val1, 32'h77);
         end
      end
      step();
      chk("drain_done", 32'(bus.alu_valid), 0);

      // flush with 6 busy, 2 ready
      for (int i = 0; i < 6; i++) begin
         issue(OP_AND, 0, 1, (i < 2) ? 6'd2 : 6'd3, 1, 0, 0,
               6'(32 + i), 0);
      end
      bcast_alu(2, 32'h5);
      chk("fl_pre", 32'(bus.alu_valid), 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("fl_valid", 32'(bus.alu_valid), 0);
      chk("fl_full", 32'(bus.rs_full), 0);
      bcast_alu(3, 32'h6);
      chk("fl_after1", 32'(bus.alu_valid), 0);
      step();
      chk("fl_after2", 32'(bus.alu_valid), 0);
      step();
      chk("fl_after3", 32'(bus.alu_valid), 0);

      issue(OP_ADDI, 32'h55, 0, 0, 0, 0, 0, 40, 1);
      step();
      chk("post_fl_valid", 32'(bus.alu_valid), 1);
      chk("post_fl_rob", 32'(bus.alu_rob_index), 40);
      chk("post_fl_val1", bus.alu_val1, 32'h55);

      // rdy low: outputs hold, issue ignored
      rdy = 1'b0;
      issue(OP_ADDI, 32'h66, 0, 0, 0, 0, 0, 41, 2);
      step();
      chk("hold_valid", 32'(bus.alu_valid), 1);
      chk("hold_rob", 32'(bus.alu_rob_index), 40);
      rdy = 1'b1;
      step();
      chk("hold_drop1", 32'(bus.alu_valid), 0);
      step();
      chk("hold_drop2", 32'(bus.alu_valid), 0);

      // flush while rdy low is ignored
      issue(OP_OR, 0, 1, 5, 1, 0, 0, 42, 0);
      rdy = 1'b0;
      flush = 1'b1;
      step();
      rdy = 1'b1;
      flush = 1'b0;
      bcast_alu(5, 32'h99);
      chk("rdyfl_t", 32'(bus.alu_valid), 0);
      step();
      chk("rdyfl_valid", 32'(bus.alu_valid), 1);
      chk("rdyfl_rob", 32'(bus.alu_rob_index), 42);
      chk("rdyfl_val1", bus.alu_val1, 32'h99);

      // issue and dispatch in the same cycle
      issue(OP_ADD, 1, 0, 0, 2, 0, 0, 50, 0);
      issue(OP_ADD, 3, 0, 0, 4, 0, 0, 51, 0);
      chk("sim_a_valid", 32'(bus.alu_valid), 1);
      chk("sim_a_rob", 32'(bus.alu_rob_index), 50);
      step();
      chk("sim_b_valid", 32'(bus.alu_valid), 1);
      chk("sim_b_rob", 32'(bus.alu_rob_index), 51);
      chk("sim_b_val1", bus.alu_val1, 3);
      step();
      chk("sim_idle", 32'(bus.alu_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule
